// File: rtl/mem_pkg.sv
// Shared types, width defaults and the pattern generator for the memory BIST initiator.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  // Pattern word for index i: seed + i. Callers truncate the result to their data width,
  // which yields the wrap-around (mod 2^DATA_W) behaviour.
  function automatic logic [31:0] bist_pattern(input logic [31:0] seed, input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/mem_rd_tracker.sv
// READ_LAT-deep pipeline that carries {valid, expected data, address} alongside an
// outstanding memory read, so the comparison lines up with the returning read data.
module mem_rd_tracker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr
);

  logic [DEPTH-1:0]  r_vld;
  logic [DATA_W-1:0] r_dat [DEPTH];
  logic [ADDR_W-1:0] r_adr [DEPTH];

  // Shift the read tag one stage per cycle; reset empties the whole pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_vld[k] <= 1'b0;
        r_dat[k] <= '0;
        r_adr[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_dat[0] <= i_data;
      r_adr[0] <= i_addr;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_dat[k] <= r_dat[k-1];
        r_adr[k] <= r_adr[k-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_data  = r_dat[DEPTH-1];
  assign o_addr  = r_adr[DEPTH-1];

endmodule

// File: rtl/mem_bist_initiator.sv
// Memory self-test master: writes seed+i to base+i for count words, reads them back,
// and reports done/pass, a saturating error count and the first failing address.
// Memory handshake: the memory has no back-pressure; mem_wr or mem_rd high in a cycle
// means one transfer in that cycle, and read data is valid exactly READ_LAT cycles later.
module mem_bist_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAT_M1 = ADDR_W'(READ_LAT - 1);

  bist_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_last, r_base, w_base_use, w_addr_nxt;
  logic [DATA_W-1:0] r_seed, w_seed_use, w_pat_nxt, r_exp;
  logic              w_accept;

  logic [ADDR_W-1:0] r_mem_addr, r_first;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_wr, r_mem_rd, r_busy, r_done, r_pass;
  logic [ERR_W-1:0]  r_err, w_err_nxt;

  logic              w_trk_valid, w_mismatch;
  logic [DATA_W-1:0] w_trk_data;
  logic [ADDR_W-1:0] w_trk_addr;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next index; the index doubles as the drain cycle counter.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = (count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (r_idx == r_last) begin
          w_state_nxt = READ;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      READ: begin
        if (r_idx == r_last) begin
          w_state_nxt = DRAIN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      DRAIN: begin
        if (r_idx == LAT_M1) begin
          w_state_nxt = DONE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // On the accept cycle the fresh inputs are used directly so the first beat is not delayed.
  assign w_base_use = w_accept ? base_addr : r_base;
  assign w_seed_use = w_accept ? seed : r_seed;
  assign w_addr_nxt = w_base_use + w_idx_nxt;
  assign w_pat_nxt  = DATA_W'(bist_pattern(32'(w_seed_use), 32'(w_idx_nxt)));

  assign w_mismatch = w_trk_valid && (mem_rdata != w_trk_data);
  assign w_err_nxt  = w_accept ? '0 :
                      (w_mismatch && !(&r_err)) ? r_err + 1'b1 : r_err;

  // Index, latched test parameters and registered memory-side outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_last      <= '0;
      r_base      <= '0;
      r_seed      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_exp       <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_accept) begin
        r_base <= base_addr;
        r_seed <= seed;
        r_last <= ADDR_W'(count - 1'b1);
      end
      r_mem_wr    <= (w_state_nxt == WRITE);
      r_mem_rd    <= (w_state_nxt == READ);
      r_mem_addr  <= (w_state_nxt == WRITE || w_state_nxt == READ) ? w_addr_nxt : '0;
      r_mem_wdata <= (w_state_nxt == WRITE) ? w_pat_nxt : '0;
      r_exp       <= (w_state_nxt == READ) ? w_pat_nxt : '0;
    end
  end

  // Status and result registers; results hold from DONE until the next accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      r_err  <= w_err_nxt;
      if (w_accept)
        r_first <= '0;
      else if (w_mismatch && r_err == '0)
        r_first <= w_trk_addr;
      if (w_state_nxt == DONE)
        r_pass <= (w_err_nxt == '0);
      else if (w_accept)
        r_pass <= 1'b0;
    end
  end

  mem_rd_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (READ_LAT)
  ) u_rd_tracker (
    .clock   (clock),
    .reset   (reset),
    .i_valid (r_mem_rd),
    .i_data  (r_exp),
    .i_addr  (r_mem_addr),
    .o_valid (w_trk_valid),
    .o_data  (w_trk_data),
    .o_addr  (w_trk_addr)
  );

  assign mem_addr       = r_mem_addr;
  assign mem_wr         = r_mem_wr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_rd         = r_mem_rd;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Bench for mem_bist_initiator: two instances (READ_LAT=1 and READ_LAT=3), each with a
// behavioural memory that can flip bit 0 on reads of selected addresses.
module tb_mem_bist_initiator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared stimulus ----------------
  logic       start1, start3;
  logic [7:0] base;
  logic [8:0] cnt;
  logic [7:0] seed;
  logic       fault [256];
  int         sel;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT with READ_LAT=1 ----------------
  logic [7:0] d1_addr, d1_wdata, d1_rdata, d1_err, d1_first;
  logic       d1_wr, d1_rd, d1_busy, d1_done, d1_pass;
  logic [2:0] d1_state;
  logic [7:0] mem1 [256];

  mem_bist_initiator #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1), .ERR_W(8)) dut1 (
    .clock(clk), .reset(rst_n), .start(start1), .base_addr(base), .count(cnt), .seed(seed),
    .mem_addr(d1_addr), .mem_wr(d1_wr), .mem_wdata(d1_wdata), .mem_rd(d1_rd),
    .mem_rdata(d1_rdata), .busy(d1_busy), .done(d1_done), .pass(d1_pass),
    .err_count(d1_err), .first_err_addr(d1_first), .dbg_state(d1_state)
  );

  always @(posedge clk) begin
    if (d1_wr) mem1[d1_addr] <= d1_wdata;
    d1_rdata <= d1_rd ? (mem1[d1_addr] ^ {7'b0, fault[d1_addr]}) : 8'h00;
  end

  // ---------------- DUT with READ_LAT=3 ----------------
  logic [7:0] d3_addr, d3_wdata, d3_rdata, d3_err, d3_first, p3_0, p3_1;
  logic       d3_wr, d3_rd, d3_busy, d3_done, d3_pass;
  logic [2:0] d3_state;
  logic [7:0] mem3 [256];

  mem_bist_initiator #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3), .ERR_W(8)) dut3 (
    .clock(clk), .reset(rst_n), .start(start3), .base_addr(base), .count(cnt), .seed(seed),
    .mem_addr(d3_addr), .mem_wr(d3_wr), .mem_wdata(d3_wdata), .mem_rd(d3_rd),
    .mem_rdata(d3_rdata), .busy(d3_busy), .done(d3_done), .pass(d3_pass),
    .err_count(d3_err), .first_err_addr(d3_first), .dbg_state(d3_state)
  );

  always @(posedge clk) begin
    if (d3_wr) mem3[d3_addr] <= d3_wdata;
    p3_0     <= d3_rd ? (mem3[d3_addr] ^ {7'b0, fault[d3_addr]}) : 8'h00;
    p3_1     <= p3_0;
    d3_rdata <= p3_1;
  end

  // ---------------- view of the selected instance ----------------
  logic [7:0] v_addr, v_wdata, v_err, v_first;
  logic       v_wr, v_rd, v_busy, v_done, v_pass;
  always_comb begin
    if (sel == 3) begin
      v_addr = d3_addr; v_wdata = d3_wdata; v_err = d3_err; v_first = d3_first;
      v_wr = d3_wr; v_rd = d3_rd; v_busy = d3_busy; v_done = d3_done; v_pass = d3_pass;
    end else begin
      v_addr = d1_addr; v_wdata = d1_wdata; v_err = d1_err; v_first = d1_first;
      v_wr = d1_wr; v_rd = d1_rd; v_busy = d1_busy; v_done = d1_done; v_pass = d1_pass;
    end
  end

  // ---------------- driver + scoreboard ----------------
  // Starts a test, then checks every write/read beat against the expected queues until done.
  // Returns the cycle in which done was seen (cycle 1 = first cycle after the start edge), or -1.
  task automatic run_bist(input int s_sel, input logic [7:0] b, input logic [8:0] n,
                          input logic [7:0] sd, input int restart_cyc, output int done_cyc);
    logic [15:0] exp_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [15:0] got_w;
    logic [7:0]  got_r, a, p;
    int          lat, budget;
    lat = (s_sel == 3) ? 3 : 1;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 8'(i);
      p = sd + 8'(i);
      exp_q.push_back({a, p});
      exp_rd_q.push_back(a);
    end
    budget   = 2 * int'(n) + lat + 20;
    done_cyc = -1;
    @(negedge clk);
    sel = s_sel; base = b; cnt = n; seed = sd;
    if (s_sel == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      checks++;
      if (v_wr && v_rd) begin
        failures++;
        $display("FAIL strobe_overlap cyc=%0d got wr=%b rd=%b expected not both", cyc, v_wr, v_rd);
      end
      if (!v_wr) begin
        checks++;
        if (v_wdata !== 8'h00) begin
          failures++;
          $display("FAIL wdata_idle cyc=%0d got=%h expected=00", cyc, v_wdata);
        end
      end
      if (v_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_write cyc=%0d got addr=%h data=%h expected no write", cyc, v_addr, v_wdata);
        end else begin
          got_w = exp_q.pop_front();
          if ({v_addr, v_wdata} !== got_w) begin
            failures++;
            $display("FAIL write_beat cyc=%0d got=%h expected=%h", cyc, {v_addr, v_wdata}, got_w);
          end
        end
      end
      if (v_rd) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          failures++;
          $display("FAIL extra_read cyc=%0d got addr=%h expected no read", cyc, v_addr);
        end else begin
          got_r = exp_rd_q.pop_front();
          if (v_addr !== got_r) begin
            failures++;
            $display("FAIL read_beat cyc=%0d got=%h expected=%h", cyc, v_addr, got_r);
          end
        end
      end
      if (v_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      checks++;
      if (v_busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_run cyc=%0d got=%b expected=1", cyc, v_busy);
      end
      if (cyc == restart_cyc) begin
        if (s_sel == 3) start3 = 1'b1; else start1 = 1'b1;
        base = 8'h80; cnt = 9'd9; seed = 8'h33;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL done_timeout got no done expected done within %0d cycles", budget);
    end
    checks++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      failures++;
      $display("FAIL missing_beats got wr_left=%0d rd_left=%0d expected 0", exp_q.size(), exp_rd_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d1_wr, d1_rd, d1_busy, d1_done, d1_pass} !== 5'b0) begin
      failures++; $display("FAIL reset_flags1 got=%b expected=00000", {d1_wr, d1_rd, d1_busy, d1_done, d1_pass});
    end
    checks++;
    if ({d1_addr, d1_wdata, d1_err, d1_first} !== 32'h0) begin
      failures++; $display("FAIL reset_words1 got=%h expected=0", {d1_addr, d1_wdata, d1_err, d1_first});
    end
    checks++;
    if ({d3_wr, d3_rd, d3_busy, d3_done, d3_pass, d3_addr, d3_wdata, d3_err, d3_first} !== 37'h0) begin
      failures++; $display("FAIL reset_all3 got=%h expected=0",
                           {d3_wr, d3_rd, d3_busy, d3_done, d3_pass, d3_addr, d3_wdata, d3_err, d3_first});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_run();
    int dc;
    run_bist(1, 8'h10, 9'd4, 8'hA0, 0, dc);
    checks++; if (dc != 10) begin failures++; $display("FAIL clean_done_cycle got=%0d expected=10", dc); end
    checks++; if (v_pass !== 1'b1) begin failures++; $display("FAIL clean_pass got=%b expected=1", v_pass); end
    checks++; if (v_err !== 8'h00) begin failures++; $display("FAIL clean_err got=%h expected=00", v_err); end
    checks++; if (v_busy !== 1'b1) begin failures++; $display("FAIL clean_busy_done got=%b expected=1", v_busy); end
    @(negedge clk);
    checks++;
    if ({v_done, v_busy, v_pass} !== 3'b001) begin
      failures++; $display("FAIL clean_after got done/busy/pass=%b expected=001", {v_done, v_busy, v_pass});
    end
  endtask

  task automatic test_wrap();
    int dc;
    run_bist(1, 8'hFE, 9'd4, 8'h3C, 0, dc);
    checks++; if (dc != 10) begin failures++; $display("FAIL wrap_done_cycle got=%0d expected=10", dc); end
    checks++; if (v_pass !== 1'b1) begin failures++; $display("FAIL wrap_pass got=%b expected=1", v_pass); end
  endtask

  task automatic test_fault();
    int dc;
    fault[8'h12] = 1'b1;
    fault[8'h14] = 1'b1;
    run_bist(1, 8'h10, 9'd8, 8'h00, 0, dc);
    checks++; if (dc != 18) begin failures++; $display("FAIL fault_done_cycle got=%0d expected=18", dc); end
    checks++; if (v_err !== 8'd2) begin failures++; $display("FAIL fault_err got=%0d expected=2", v_err); end
    checks++; if (v_first !== 8'h12) begin failures++; $display("FAIL fault_first got=%h expected=12", v_first); end
    checks++; if (v_pass !== 1'b0) begin failures++; $display("FAIL fault_pass got=%b expected=0", v_pass); end
    @(negedge clk);
    checks++;
    if ({v_pass, v_err, v_first} !== {1'b0, 8'd2, 8'h12}) begin
      failures++; $display("FAIL fault_hold got=%h expected=%h", {v_pass, v_err, v_first}, {1'b0, 8'd2, 8'h12});
    end
    fault[8'h12] = 1'b0;
    fault[8'h14] = 1'b0;
  endtask

  task automatic test_count_zero();
    int dc;
    run_bist(1, 8'h40, 9'd0, 8'h11, 0, dc);
    checks++; if (dc != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d expected=1", dc); end
    checks++; if (v_pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%b expected=1", v_pass); end
    checks++;
    if ({v_err, v_first} !== 16'h0) begin
      failures++; $display("FAIL zero_results got=%h expected=0000", {v_err, v_first});
    end
  endtask

  task automatic test_full_sweep();
    int dc;
    run_bist(3, 8'h37, 9'd256, 8'hFF, 0, dc);
    checks++; if (dc != 516) begin failures++; $display("FAIL sweep_done_cycle got=%0d expected=516", dc); end
    checks++; if (v_pass !== 1'b1) begin failures++; $display("FAIL sweep_pass got=%b expected=1", v_pass); end
    checks++; if (v_err !== 8'h00) begin failures++; $display("FAIL sweep_err got=%h expected=00", v_err); end
  endtask

  task automatic test_reset_mid_read();
    int dc;
    @(negedge clk);
    sel = 1; base = 8'h20; cnt = 9'd4; seed = 8'h55; start1 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    checks++; if (d1_rd !== 1'b1) begin failures++; $display("FAIL midrd_reading got=%b expected=1", d1_rd); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d1_wr, d1_rd, d1_busy, d1_done, d1_pass, d1_addr, d1_wdata, d1_err, d1_first} !== 37'h0) begin
      failures++; $display("FAIL midrd_reset_outs got=%h expected=0",
                           {d1_wr, d1_rd, d1_busy, d1_done, d1_pass, d1_addr, d1_wdata, d1_err, d1_first});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      checks++;
      if (d1_done !== 1'b0 || d1_busy !== 1'b0) begin
        failures++; $display("FAIL midrd_no_done k=%0d got done/busy=%b expected=00", k, {d1_done, d1_busy});
      end
    end
    run_bist(1, 8'h20, 9'd4, 8'h55, 0, dc);
    checks++; if (dc != 10) begin failures++; $display("FAIL midrd_restart_cycle got=%0d expected=10", dc); end
    checks++; if (v_pass !== 1'b1) begin failures++; $display("FAIL midrd_restart_pass got=%b expected=1", v_pass); end
  endtask

  task automatic test_start_ignored();
    int dc;
    run_bist(1, 8'h10, 9'd4, 8'hA0, 3, dc);
    checks++; if (dc != 10) begin failures++; $display("FAIL ignore_done_cycle got=%0d expected=10", dc); end
    checks++; if (v_pass !== 1'b1) begin failures++; $display("FAIL ignore_pass got=%b expected=1", v_pass); end
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({v_busy, v_wr, v_rd} !== 3'b000) begin
      failures++; $display("FAIL ignore_no_rerun got busy/wr/rd=%b expected=000", {v_busy, v_wr, v_rd});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    start1 = 1'b0; start3 = 1'b0;
    base = '0; cnt = '0; seed = '0; sel = 1;
    for (int k = 0; k < 256; k++) fault[k] = 1'b0;
    test_reset();
    test_clean_run();
    test_wrap();
    test_fault();
    test_count_zero();
    test_full_sweep();
    test_reset_mid_read();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
